// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter register with vectored ISR entry and hardware return stack
//
// Purpose: holds the CPU program counter and selects its next value from the
// controller's pc_op. Interrupt entry pushes the interrupted pc onto a small
// LIFO so nested ISRs return without a register-file save.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   enable            1 = apply pc_op this cycle, 0 = hold all state
//   pc_op             0 NOP, 1 PLUS, 2 LOAD_RFA, 3 LOAD_CALC, 4 ISR, 5 IRET, 6 SOFT_RESET, 7 NOP
//   rfa_value         register-file jump target, also the IRET fallback on an empty stack
//   calc_value        ALU-computed jump target
//   vector_index      ISR vector selector
//   pc, pc_plus       current pc (registered) and pc + INSTR_BYTES (combinational)
//   depth             occupied return-stack entries; stack_empty / stack_full decode it
//   misaligned        one-cycle pulse: a loaded target had its low bits discarded
//   overflow          one-cycle pulse: ISR with the stack full
//   underflow         one-cycle pulse: IRET with the stack empty

module pc_sequencer #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           INSTR_BYTES  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE  = 'h0000_0100,
    parameter int unsigned           VECTOR_COUNT = 16,
    parameter int unsigned           SAVE_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [2:0]                        pc_op,
    input  logic [ADDR_WIDTH-1:0]             rfa_value,
    input  logic [ADDR_WIDTH-1:0]             calc_value,
    input  logic [$clog2(VECTOR_COUNT)-1:0]   vector_index,
    output logic [ADDR_WIDTH-1:0]             pc,
    output logic [ADDR_WIDTH-1:0]             pc_plus,
    output logic [$clog2(SAVE_DEPTH+1)-1:0]   depth,
    output logic                              stack_empty,
    output logic                              stack_full,
    output logic                              misaligned,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned           DEPTH_W   = $clog2(SAVE_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [DEPTH_W-1:0]    DEPTH_MAX = DEPTH_W'(SAVE_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_PLUS       = 3'd1,
        OP_LOAD_RFA   = 3'd2,
        OP_LOAD_CALC  = 3'd3,
        OP_ISR        = 3'd4,
        OP_IRET       = 3'd5,
        OP_SOFT_RESET = 3'd6,
        OP_NOP7       = 3'd7
    } pc_op_e;

    // Parameter sanity checks at elaboration.
    if (INSTR_BYTES == 0 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_bad_instr_bytes
        $error("pc_sequencer: INSTR_BYTES must be a power of 2");
    end
    if (VECTOR_COUNT < 2 || (VECTOR_COUNT & (VECTOR_COUNT - 1)) != 0) begin : g_bad_vector_count
        $error("pc_sequencer: VECTOR_COUNT must be a power of 2 and >= 2");
    end
    if ((RESET_VECTOR & LOW_MASK) != '0) begin : g_bad_reset_vector
        $error("pc_sequencer: RESET_VECTOR is not instruction aligned");
    end
    if ((VECTOR_BASE & LOW_MASK) != '0) begin : g_bad_vector_base
        $error("pc_sequencer: VECTOR_BASE is not instruction aligned");
    end
    if (SAVE_DEPTH < 1) begin : g_bad_save_depth
        $error("pc_sequencer: SAVE_DEPTH must be >= 1");
    end

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic                  misaligned_q, misaligned_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [ADDR_WIDTH-1:0] stack_q [SAVE_DEPTH];

    pc_op_e                op;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] top_entry;
    logic [ADDR_WIDTH-1:0] vector_addr;

    assign op          = pc_op_e'(pc_op);
    assign full        = (depth_q == DEPTH_MAX);
    assign empty       = (depth_q == '0);
    assign vector_addr = VECTOR_BASE + ADDR_WIDTH'(vector_index) * STEP;

    // Top of stack lives at index depth-1; selecting by compare keeps the
    // index width independent of whether SAVE_DEPTH is a power of 2.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < int'(SAVE_DEPTH); i++) begin
            if (DEPTH_W'(i + 1) == depth_q) begin
                top_entry = stack_q[i];
            end
        end
    end

    always_comb begin
        pc_d         = pc_q;
        depth_d      = depth_q;
        misaligned_d = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        push         = 1'b0;
        if (enable) begin
            unique case (op)
                OP_PLUS: begin
                    pc_d = pc_q + STEP;
                end
                OP_LOAD_RFA: begin
                    pc_d         = rfa_value & ~LOW_MASK;
                    misaligned_d = |(rfa_value & LOW_MASK);
                end
                OP_LOAD_CALC: begin
                    pc_d         = calc_value & ~LOW_MASK;
                    misaligned_d = |(calc_value & LOW_MASK);
                end
                OP_ISR: begin
                    if (!full) begin
                        push    = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                        pc_d    = vector_addr;
                    end else begin
                        // Vector 0 is the stack-overflow handler.
                        pc_d       = VECTOR_BASE;
                        overflow_d = 1'b1;
                    end
                end
                OP_IRET: begin
                    if (!empty) begin
                        pc_d         = top_entry & ~LOW_MASK;
                        misaligned_d = |(top_entry & LOW_MASK);
                        depth_d      = depth_q - DEPTH_W'(1);
                    end else begin
                        // Software saved the return address in a register.
                        pc_d         = rfa_value & ~LOW_MASK;
                        misaligned_d = |(rfa_value & LOW_MASK);
                        underflow_d  = 1'b1;
                    end
                end
                OP_SOFT_RESET: begin
                    pc_d    = RESET_VECTOR;
                    depth_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            depth_q      <= '0;
            misaligned_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            depth_q      <= depth_d;
            misaligned_q <= misaligned_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Stack contents need no reset: depth alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            for (int i = 0; i < int'(SAVE_DEPTH); i++) begin
                if (DEPTH_W'(i) == depth_q) begin
                    stack_q[i] <= pc_q;
                end
            end
        end
    end

    assign pc          = pc_q;
    assign pc_plus     = pc_q + STEP;
    assign depth       = depth_q;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign misaligned  = misaligned_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PLUS  = 3'd1;
    localparam logic [2:0] OP_RFA   = 3'd2;
    localparam logic [2:0] OP_CALC  = 3'd3;
    localparam logic [2:0] OP_ISR   = 3'd4;
    localparam logic [2:0] OP_IRET  = 3'd5;
    localparam logic [2:0] OP_SOFT  = 3'd6;
    localparam logic [2:0] OP_NOP7  = 3'd7;

    localparam logic [31:0] INSTR     = 32'd4;
    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] VBASE     = 32'h100;
    localparam int          SDEPTH    = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic [2:0]  pc_op;
    logic [31:0] rfa_value;
    logic [31:0] calc_value;
    logic [3:0]  vector_index;

    logic [31:0] pc, pc_plus;
    logic [2:0]  depth;
    logic        stack_empty, stack_full, misaligned, overflow, underflow;

    logic [15:0] pc16, pc_plus16;
    logic [2:0]  depth16;
    logic        empty16, full16, mis16, ovf16, und16;

    pc_sequencer u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pc_op        (pc_op),
        .rfa_value    (rfa_value),
        .calc_value   (calc_value),
        .vector_index (vector_index),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .depth        (depth),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .misaligned   (misaligned),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    pc_sequencer #(
        .ADDR_WIDTH   (16),
        .RESET_VECTOR (16'h0000),
        .VECTOR_BASE  (16'h0100)
    ) u_dut16 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pc_op        (pc_op),
        .rfa_value    (rfa_value[15:0]),
        .calc_value   (calc_value[15:0]),
        .vector_index (vector_index),
        .pc           (pc16),
        .pc_plus      (pc_plus16),
        .depth        (depth16),
        .stack_empty  (empty16),
        .stack_full   (full16),
        .misaligned   (mis16),
        .overflow     (ovf16),
        .underflow    (und16)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: pc as plain modulo-2^32 arithmetic, return stack as a queue.
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    bit          m_mis, m_ovf, m_und;

    task automatic model_step(input bit rst, input bit en, input logic [2:0] op,
                              input logic [31:0] rfa, input logic [31:0] calc, input logic [3:0] vi);
        logic [31:0] t;
        m_mis = 1'b0;
        m_ovf = 1'b0;
        m_und = 1'b0;
        if (rst) begin
            m_pc = RESET_VEC;
            m_stack.delete();
            return;
        end
        if (!en) return;
        case (op)
            OP_PLUS: m_pc = m_pc + INSTR;
            OP_RFA: begin
                m_pc  = rfa - (rfa % INSTR);
                m_mis = (rfa % INSTR) != 0;
            end
            OP_CALC: begin
                m_pc  = calc - (calc % INSTR);
                m_mis = (calc % INSTR) != 0;
            end
            OP_ISR: begin
                if (m_stack.size() < SDEPTH) begin
                    m_stack.push_back(m_pc);
                    m_pc = VBASE + 32'(vi) * INSTR;
                end else begin
                    m_pc  = VBASE;
                    m_ovf = 1'b1;
                end
            end
            OP_IRET: begin
                if (m_stack.size() > 0) begin
                    t     = m_stack.pop_back();
                    m_pc  = t - (t % INSTR);
                    m_mis = (t % INSTR) != 0;
                end else begin
                    m_pc  = rfa - (rfa % INSTR);
                    m_mis = (rfa % INSTR) != 0;
                    m_und = 1'b1;
                end
            end
            OP_SOFT: begin
                m_pc = RESET_VEC;
                m_stack.delete();
            end
            default: ;
        endcase
    endtask

    task automatic apply(input bit rst, input bit en, input logic [2:0] op,
                         input logic [31:0] rfa, input logic [31:0] calc, input logic [3:0] vi);
        @(negedge clk);
        reset        = rst;
        enable       = en;
        pc_op        = op;
        rfa_value    = rfa;
        calc_value   = calc;
        vector_index = vi;
        @(posedge clk);
        #1;
        model_step(rst, en, op, rfa, calc, vi);
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc"},        pc,                 m_pc);
        check({tag, " pc_plus"},   pc_plus,            m_pc + INSTR);
        check({tag, " depth"},     32'(depth),         32'(m_stack.size()));
        check({tag, " empty"},     32'(stack_empty),   32'(m_stack.size() == 0));
        check({tag, " full"},      32'(stack_full),    32'(m_stack.size() == SDEPTH));
        check({tag, " misalign"},  32'(misaligned),    32'(m_mis));
        check({tag, " overflow"},  32'(overflow),      32'(m_ovf));
        check({tag, " underflow"}, 32'(underflow),     32'(m_und));
    endtask

    typedef struct {
        bit          en;
        logic [2:0]  op;
        logic [31:0] rfa;
        logic [31:0] calc;
        logic [3:0]  vi;
        logic [31:0] e_pc;
        int          e_depth;
        bit          e_mis;
        bit          e_ovf;
        bit          e_und;
    } vec_t;

    vec_t tbl[$];

    bit          r_rst, r_en;
    logic [2:0]  r_op;
    logic [31:0] r_rfa, r_calc;
    logic [3:0]  r_vi;
    int          r_sel;

    initial begin
        // en, op, rfa, calc, vi, pc, depth, mis, ovf, und (from reset pc=0)
        tbl.push_back('{1, OP_PLUS, 32'h0,        32'h0,    4'd0, 32'h4,        0, 0, 0, 0});
        tbl.push_back('{1, OP_PLUS, 32'h0,        32'h0,    4'd0, 32'h8,        0, 0, 0, 0});
        tbl.push_back('{1, OP_PLUS, 32'h0,        32'h0,    4'd0, 32'hC,        0, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h1002,     32'h0,    4'd0, 32'h1000,     0, 1, 0, 0});
        tbl.push_back('{1, OP_CALC, 32'h0,        32'h2000, 4'd0, 32'h2000,     0, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h40,       32'h0,    4'd0, 32'h40,       0, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd3, 32'h10C,      1, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd5, 32'h114,      2, 0, 0, 0});
        tbl.push_back('{1, OP_IRET, 32'h0,        32'h0,    4'd0, 32'h10C,      1, 0, 0, 0});
        tbl.push_back('{1, OP_IRET, 32'h0,        32'h0,    4'd0, 32'h40,       0, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd1, 32'h104,      1, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h44,       32'h0,    4'd0, 32'h44,       1, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd2, 32'h108,      2, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h48,       32'h0,    4'd0, 32'h48,       2, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd3, 32'h10C,      3, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h4C,       32'h0,    4'd0, 32'h4C,       3, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd4, 32'h110,      4, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h50,       32'h0,    4'd0, 32'h50,       4, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd7, 32'h100,      4, 0, 1, 0});
        tbl.push_back('{1, OP_IRET, 32'hDEAD0003, 32'h0,    4'd0, 32'h4C,       3, 0, 0, 0});
        tbl.push_back('{1, OP_IRET, 32'h0,        32'h0,    4'd0, 32'h48,       2, 0, 0, 0});
        tbl.push_back('{1, OP_IRET, 32'h0,        32'h0,    4'd0, 32'h44,       1, 0, 0, 0});
        tbl.push_back('{1, OP_IRET, 32'h0,        32'h0,    4'd0, 32'h40,       0, 0, 0, 0});
        tbl.push_back('{1, OP_IRET, 32'h80,       32'h0,    4'd0, 32'h80,       0, 0, 0, 1});
        tbl.push_back('{1, OP_IRET, 32'h83,       32'h0,    4'd0, 32'h80,       0, 1, 0, 1});
        tbl.push_back('{1, OP_NOP7, 32'h7,        32'h0,    4'd0, 32'h80,       0, 0, 0, 0});
        tbl.push_back('{0, OP_PLUS, 32'h0,        32'h0,    4'd0, 32'h80,       0, 0, 0, 0});
        tbl.push_back('{1, OP_ISR,  32'h0,        32'h0,    4'd0, 32'h100,      1, 0, 0, 0});
        tbl.push_back('{1, OP_SOFT, 32'h0,        32'h0,    4'd0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'hFFFFFFFF, 32'h0,    4'd0, 32'hFFFFFFFC, 0, 1, 0, 0});
        tbl.push_back('{1, OP_PLUS, 32'h0,        32'h0,    4'd0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{1, OP_RFA,  32'h5,        32'h0,    4'd0, 32'h4,        0, 1, 0, 0});
        tbl.push_back('{0, OP_PLUS, 32'h0,        32'h0,    4'd0, 32'h4,        0, 0, 0, 0});

        reset = 1'b1; enable = 1'b0; pc_op = OP_NOP;
        rfa_value = '0; calc_value = '0; vector_index = '0;
        apply(1, 0, OP_NOP, 0, 0, 0);
        apply(1, 0, OP_NOP, 0, 0, 0);

        check("reset pc",        pc,                32'h0);
        check("reset pc_plus",   pc_plus,           32'h4);
        check("reset depth",     32'(depth),        32'd0);
        check("reset empty",     32'(stack_empty),  32'd1);
        check("reset full",      32'(stack_full),   32'd0);
        check("reset pulses",    32'({misaligned, overflow, underflow}), 32'd0);

        foreach (tbl[i]) begin
            apply(0, tbl[i].en, tbl[i].op, tbl[i].rfa, tbl[i].calc, tbl[i].vi);
            check($sformatf("vec%0d pc", i),        pc,                tbl[i].e_pc);
            check($sformatf("vec%0d pc_plus", i),   pc_plus,           tbl[i].e_pc + 32'd4);
            check($sformatf("vec%0d depth", i),     32'(depth),        32'(tbl[i].e_depth));
            check($sformatf("vec%0d empty", i),     32'(stack_empty),  32'(tbl[i].e_depth == 0));
            check($sformatf("vec%0d full", i),      32'(stack_full),   32'(tbl[i].e_depth == 4));
            check($sformatf("vec%0d misalign", i),  32'(misaligned),   32'(tbl[i].e_mis));
            check($sformatf("vec%0d overflow", i),  32'(overflow),     32'(tbl[i].e_ovf));
            check($sformatf("vec%0d underflow", i), 32'(underflow),    32'(tbl[i].e_und));
        end

        // ISR held off by enable=0 for three cycles, then applied exactly once.
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, OP_ISR, 0, 0, 4'd2);
            check($sformatf("stall%0d pc", k),    pc,         32'h4);
            check($sformatf("stall%0d depth", k), 32'(depth), 32'd0);
        end
        apply(0, 1, OP_ISR, 0, 0, 4'd2);
        check("release pc",    pc,         32'h108);
        check("release depth", 32'(depth), 32'd1);
        apply(0, 1, OP_NOP, 0, 0, 4'd2);
        check("after pc",      pc,         32'h108);
        check("after depth",   32'(depth), 32'd1);

        // 16-bit instance: wrap at the top of the address space, then reset mid-nesting.
        apply(1, 0, OP_NOP, 0, 0, 0);
        apply(0, 1, OP_RFA, 32'hFFFC, 0, 0);
        check("w16 load pc",    32'(pc16),      32'hFFFC);
        apply(0, 1, OP_PLUS, 0, 0, 0);
        check("w16 wrap pc",    32'(pc16),      32'h0000);
        check("w16 wrap plus",  32'(pc_plus16), 32'h0004);
        check("w16 wrap flags", 32'({mis16, ovf16, und16}), 32'd0);
        check_model("w32 nowrap");
        apply(0, 1, OP_ISR, 0, 0, 4'd1);
        apply(0, 1, OP_ISR, 0, 0, 4'd2);
        check("w16 nest pc",    32'(pc16),      32'h0108);
        check("w16 nest depth", 32'(depth16),   32'd2);
        apply(1, 1, OP_RFA, 32'h3, 0, 0);
        check("w16 rst pc",     32'(pc16),      32'h0000);
        check("w16 rst depth",  32'(depth16),   32'd0);
        check("w16 rst empty",  32'(empty16),   32'd1);
        check("w16 rst full",   32'(full16),    32'd0);
        check("w16 rst pulses", 32'({mis16, ovf16, und16}), 32'd0);
        check_model("w32 rst");

        // Randomised traffic against the queue model.
        for (int k = 0; k < 600; k++) begin
            r_rst  = ($urandom_range(0, 99) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            r_sel  = $urandom_range(0, 15);
            if (r_sel < 5)      r_op = OP_ISR;
            else if (r_sel < 9) r_op = OP_IRET;
            else                r_op = 3'($urandom_range(0, 7));
            r_rfa  = $urandom;
            r_calc = $urandom;
            if ($urandom_range(0, 1) == 1) r_rfa[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) r_calc[1:0] = 2'b00;
            r_vi   = 4'($urandom_range(0, 15));
            apply(r_rst, r_en, r_op, r_rfa, r_calc, r_vi);
            check_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
